// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised, PRESCALE-oversampled, optional parity, one stop bit.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE0   = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] CNT_PRE1   = CW'(PRESCALE/2);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(PRESCALE/2 + 1);
`else
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(PRESCALE/2);
`endif

  logic [2:0]            state;
  logic                  rx_m;
  logic                  rx_s;
  logic                  rx_d;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_bad;
  logic                  sample_bit;
  logic                  at_sample;
  logic                  at_last;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] pre;

  // The two earlier votes are held; the third is the live rx_s at the decision cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= 2'b11;
    end else begin
      if (edge_cnt == CNT_PRE0) pre[0] <= rx_s;
      if (edge_cnt == CNT_PRE1) pre[1] <= rx_s;
    end
  end

  always_comb begin
    sample_bit = (pre[0] & pre[1]) | (pre[0] & rx_s) | (pre[1] & rx_s);
  end
`else
  always_comb begin
    sample_bit = rx_s;
  end
`endif

  always_comb begin
    at_sample = (edge_cnt == CNT_SAMPLE);
    at_last   = (edge_cnt == CNT_LAST);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;

      if (state == IDLE || at_last) edge_cnt <= '0;
      else                          edge_cnt <= edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (rx_d && !rx_s) begin
            state     <= START;
            par_en_l  <= par_en;
            par_typ_l <= par_typ;
            par_bad   <= 1'b0;
          end
        end
        START: begin
          if (at_sample && sample_bit) state <= IDLE;
          else if (at_last)            state <= DATA;
        end
        DATA: begin
          if (at_sample) shift_reg[bit_cnt] <= sample_bit;
          if (at_last) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_sample) par_bad <= (sample_bit != ((^shift_reg) ^ par_typ_l));
          if (at_last)   state   <= STOP;
        end
        STOP: begin
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (at_sample) begin
            state    <= IDLE;
            par_err  <= par_bad;
            stop_err <= !sample_bit;
            if (!par_bad && sample_bit) begin
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's UART transmitter; same frame format.
- Frame: idle-high line, start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Oversamples rx_in at PRESCALE clk cycles per bit and recovers the byte.
- Flags parity and framing errors; delivers the byte to the register/FIFO side with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE, 8, clk cycles per bit; even, >= 4.

Ports:
- clk  input  1  oversampling clock, PRESCALE x baud rate.
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line, asynchronous to clk; idles high.
- par_en  input  1  1 = parity bit present in frame.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- p_data  output  DATA_WIDTH  received data; holds last good value.
- data_valid  output  1  one-cycle pulse, p_data updated.
- par_err  output  1  one-cycle pulse, parity mismatch.
- stop_err  output  1  one-cycle pulse, stop bit sampled 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Single clock domain clk. Reset asynchronous, active-low on rst.
- Reset values: p_data = 0, data_valid = 0, par_err = 0, stop_err = 0, busy = 0. State = IDLE, all counters 0, synchroniser flops = 1.
- rx_in passes through a 2-flop synchroniser (rx_s). Edge detection uses rx_s and its 1-cycle delayed copy.
- edge_cnt: width clog2(PRESCALE), counts 0..PRESCALE-1, wraps to 0; cleared on entry to START.
- Sample point: edge_cnt == PRESCALE/2. The bit value is the rx_s value at that cycle.
- bit_cnt counts data bits 0..DATA_WIDTH-1.
- par_en and par_typ are latched at start detection. Changes mid-frame have no effect on the current frame.
- States and transitions:
  - IDLE: on rx_s falling edge (delayed = 1, rx_s = 0) go to START, clear edge_cnt.
  - START: at the sample point, if sample = 1 it is a glitch: return to IDLE, no outputs. Else, at edge_cnt == PRESCALE-1, go to DATA.
  - DATA: at the sample point, shift the sample into the shift register at bit position bit_cnt (LSB first). At edge_cnt == PRESCALE-1 after bit DATA_WIDTH-1, go to PARITY if the latched par_en = 1, else go to STOP.
  - PARITY: at the sample point compare the sample to the expected parity. Even: XOR of data bits. Odd: inverted XOR. Store a mismatch flag. At edge_cnt == PRESCALE-1, go to STOP.
  - STOP: at the sample point, resolve the frame and go to IDLE in the same cycle. Returning at mid-stop allows back-to-back frames with a full stop bit.
- Resolution (outputs registered, asserted the cycle after the stop sample point):
  - No errors: p_data <= shift register, data_valid = 1.
  - Parity mismatch: par_err = 1.
  - Stop sample = 0: stop_err = 1.
  - On any error, data_valid = 0 and p_data is unchanged. par_err and stop_err may pulse together.
- Latency: data_valid rises 2 (sync) + 1 + PRESCALE*(1 + DATA_WIDTH + par_en) + PRESCALE/2 clk after the rx_in falling edge.
- Pulses are exactly 1 cycle and are cleared automatically the next cycle.
- busy = 1 from the START entry cycle through the STOP resolution cycle.
- Reset asserted mid-frame: immediate return to reset values. No partial data_valid and no error pulse.
- A line held low after a stop error does not retrigger. A new start needs a fresh 1->0 edge on rx_s.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each bit is decided by a 2-of-3 majority of rx_s at edge_cnt == PRESCALE/2-1, PRESCALE/2, and PRESCALE/2+1.
  - The decision, start-glitch check, and stop resolution happen at PRESCALE/2+1; the STOP -> IDLE return also happens there.
  - Latency above increases by 1 clk.
- Not defined: single sample at PRESCALE/2, as above.

Test Plan:
- par_en = 0, send 0xA5 at PRESCALE = 8 -> one data_valid pulse, p_data = 0xA5, par_err = 0, stop_err = 0, busy low afterwards.
- par_en = 1, par_typ = 0, send 0x3C with parity bit 0 -> data_valid, p_data = 0x3C. Same frame with parity bit 1 -> par_err pulse, data_valid = 0, p_data keeps its previous value.
- par_en = 1, par_typ = 1, send 0x01 with stop bit driven 0 and correct parity 0 -> stop_err pulse only. Same frame with parity bit 1 as well -> par_err and stop_err pulse in the same cycle.
- rx_in low for 2 clk then high -> START aborts at the sample point; no outputs; busy returns to 0; next valid frame 0x5A received correctly.
- Back-to-back frames 0x11, 0xEE with no idle gap -> two data_valid pulses, p_data = 0x11 then 0xEE.
- Reset pulsed during data bit 4 -> all outputs 0 immediately; following frame 0x7E received correctly. With UART_RX_MAJORITY_EN, a 1-clk glitch at the mid-point of data bit 3 of 0xFF -> still p_data = 0xFF.
